ex_muldiv_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline, directly upstream of the memory stage.
- Computes the ALU result, which becomes the memory address or pass-through data, and forwards store data plus control.
- Registers all of these into the EX/MEM latch that feeds the memory stage.
- Hosts the iterative HI/LO multiply/divide unit; stalls the front end while a dependent instruction waits on it.

---
 rtl/ex_muldiv_stage_pkg.sv | 34 +++
 rtl/ex_muldiv_stage_if.sv | 51 +++++
 rtl/ex_muldiv_stage_mul_div_unit.sv | 130 +++++++++++++
 rtl/ex_muldiv_stage.sv | 116 +++++++++++
 tb/tb_ex_muldiv_stage.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_stage_pkg.sv
// Shared constants for the execute stage: ALU opcodes, mul/div op and HI/LO select codes,
// control-field widths and the mul/div FSM state type.
package ex_muldiv_stage_pkg;

  localparam int NB_REG     = 5;
  localparam int NB_CTR_WB  = 2;
  localparam int NB_CTR_MEM = 8;
  localparam int NB_MEM_CTL = NB_CTR_MEM >> 1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [1:0] MD_OP_MULT  = 2'd0;
  localparam logic [1:0] MD_OP_MULTU = 2'd1;
  localparam logic [1:0] MD_OP_DIV   = 2'd2;
  localparam logic [1:0] MD_OP_DIVU  = 2'd3;

  localparam logic [1:0] HILO_SEL_NONE = 2'd0;
  localparam logic [1:0] HILO_SEL_HI   = 2'd1;
  localparam logic [1:0] HILO_SEL_LO   = 2'd2;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

endpackage

// File: rtl/ex_muldiv_stage_if.sv
// Execute-stage bus: ID/EX inputs, EX/MEM latch outputs, stall and busy.
// o_ovf exists only when EX_OVERFLOW_TRAP_EN is defined.
interface ex_muldiv_stage_if
  import ex_muldiv_stage_pkg::*;
#(
  parameter int NB_BITS   = 32,
  parameter int NB_ALU_OP = 4
);
  logic [NB_BITS-1:0]   i_rs_data;
  logic [NB_BITS-1:0]   i_rt_data;
  logic [NB_BITS-1:0]   i_imm;
  logic [4:0]           i_shamt;
  logic [NB_ALU_OP-1:0] i_alu_op;
  logic                 i_alu_src;
  logic                 i_md_start;
  logic [1:0]           i_md_op;
  logic [1:0]           i_hilo_sel;
  logic [NB_MEM_CTL-1:0] i_write_ctl;
  logic [NB_MEM_CTL-1:0] i_read_ctl;
  logic [NB_REG-1:0]    i_reg_dst;
  logic [NB_CTR_WB-1:0] i_wb_ctl;
  logic [NB_BITS-1:0]   o_addr;
  logic [NB_BITS-1:0]   o_data;
  logic [NB_MEM_CTL-1:0] o_write_ctl;
  logic [NB_MEM_CTL-1:0] o_read_ctl;
  logic [NB_REG-1:0]    o_reg_dst;
  logic [NB_CTR_WB-1:0] o_wb_ctl;
  logic                 o_stall;
  logic                 o_md_busy;
`ifdef EX_OVERFLOW_TRAP_EN
  logic                 o_ovf;
`endif

  modport slave (
`ifdef EX_OVERFLOW_TRAP_EN
    output o_ovf,
`endif
    input  i_rs_data, i_rt_data, i_imm, i_shamt, i_alu_op, i_alu_src, i_md_start,
           i_md_op, i_hilo_sel, i_write_ctl, i_read_ctl, i_reg_dst, i_wb_ctl,
    output o_addr, o_data, o_write_ctl, o_read_ctl, o_reg_dst, o_wb_ctl, o_stall, o_md_busy
  );

  modport master (
`ifdef EX_OVERFLOW_TRAP_EN
    input  o_ovf,
`endif
    output i_rs_data, i_rt_data, i_imm, i_shamt, i_alu_op, i_alu_src, i_md_start,
           i_md_op, i_hilo_sel, i_write_ctl, i_read_ctl, i_reg_dst, i_wb_ctl,
    input  o_addr, o_data, o_write_ctl, o_read_ctl, o_reg_dst, o_wb_ctl, o_stall, o_md_busy
  );
endinterface

// File: rtl/ex_muldiv_stage_mul_div_unit.sv
// Iterative HI/LO unit: magnitude shift-add multiply / restoring divide, one bit per cycle,
// sign correction applied in DONE when HI/LO are written.
module mul_div_unit
  import ex_muldiv_stage_pkg::*;
#(
  parameter int NB_BITS   = 32,
  parameter int NB_MD_CNT = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [1:0]         i_op,
  input  logic [NB_BITS-1:0] i_a,
  input  logic [NB_BITS-1:0] i_b,
  output logic [NB_BITS-1:0] o_hi,
  output logic [NB_BITS-1:0] o_lo,
  output logic               o_busy
);

  function automatic logic [NB_BITS-1:0] f_neg_if(input logic [NB_BITS-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*NB_BITS-1:0] f_neg_wide_if(input logic [2*NB_BITS-1:0] x,
                                                         input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  md_state_e              r_state;
  logic [NB_MD_CNT-1:0]   r_cnt;
  logic [NB_BITS-1:0]     r_acc, r_ext, r_opb, r_hi, r_lo;
  logic                   r_is_div, r_neg_q, r_neg_r, r_busy;

  logic                   w_signed, w_a_neg, w_b_neg;
  logic [NB_BITS-1:0]     w_mag_a, w_mag_b;
  logic [NB_BITS:0]       w_mul_sum, w_rem_sh, w_diff;
  logic [2*NB_BITS-1:0]   w_prod;

  assign w_signed = (i_op == MD_OP_MULT) || (i_op == MD_OP_DIV);
  assign w_a_neg  = w_signed & i_a[NB_BITS-1];
  assign w_b_neg  = w_signed & i_b[NB_BITS-1];
  assign w_mag_a  = f_neg_if(i_a, w_a_neg);
  assign w_mag_b  = f_neg_if(i_b, w_b_neg);

  // r_acc holds the product high half / partial remainder, r_ext the multiplier / quotient
  assign w_mul_sum = {1'b0, r_acc} + (r_ext[0] ? {1'b0, r_opb} : '0);
  assign w_rem_sh  = {r_acc, r_ext[NB_BITS-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_opb};
  assign w_prod    = f_neg_wide_if({r_acc, r_ext}, r_neg_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_ext    <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_is_div <= i_op[1];
            r_opb    <= w_mag_b;
            r_neg_r  <= w_a_neg;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            if (i_op[1] && (i_b == '0)) begin
              // Divide by zero skips iteration: LO all ones, HI the original dividend
              r_acc   <= w_mag_a;
              r_ext   <= '1;
              r_neg_q <= 1'b0;
              r_state <= MD_DONE;
            end else begin
              r_acc   <= '0;
              r_ext   <= w_mag_a;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_state <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          if (r_is_div) begin
            if (!w_diff[NB_BITS]) begin
              r_acc <= w_diff[NB_BITS-1:0];
              r_ext <= {r_ext[NB_BITS-2:0], 1'b1};
            end else begin
              r_acc <= w_rem_sh[NB_BITS-1:0];
              r_ext <= {r_ext[NB_BITS-2:0], 1'b0};
            end
          end else begin
            r_acc <= w_mul_sum[NB_BITS:1];
            r_ext <= {w_mul_sum[0], r_ext[NB_BITS-1:1]};
          end
          if (r_cnt == NB_MD_CNT'(NB_BITS-1)) begin
            r_cnt   <= '0;
            r_state <= MD_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        MD_DONE: begin
          if (r_is_div) begin
            r_lo <= f_neg_if(r_ext, r_neg_q);
            r_hi <= f_neg_if(r_acc, r_neg_r);
          end else begin
            r_lo <= w_prod[NB_BITS-1:0];
            r_hi <= w_prod[2*NB_BITS-1:NB_BITS];
          end
          r_busy  <= 1'b0;
          r_state <= MD_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= MD_IDLE;
        end
      endcase
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = r_busy;

endmodule

// File: rtl/ex_muldiv_stage.sv
// MIPS execute stage: combinational ALU, HI/LO read mux and the EX/MEM latch.
// Optional EX_OVERFLOW_TRAP_EN: signed ADD/SUB overflow squashes the write and pulses o_ovf.
module ex_muldiv_stage
  import ex_muldiv_stage_pkg::*;
#(
  parameter int NB_BITS   = 32,
  parameter int NB_ALU_OP = 4,
  parameter int NB_MD_CNT = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ex_muldiv_stage_if.slave ex_if
);

  logic [NB_BITS-1:0]        w_b, w_alu, w_hi, w_lo, w_addr;
  logic signed [NB_BITS-1:0] w_a_s, w_b_s;
  logic                      w_busy, w_stall, w_kill;

  logic [NB_BITS-1:0]    r_addr, r_data;
  logic [NB_MEM_CTL-1:0] r_write_ctl, r_read_ctl;
  logic [NB_REG-1:0]     r_reg_dst;
  logic [NB_CTR_WB-1:0]  r_wb_ctl;

  assign w_b   = ex_if.i_alu_src ? ex_if.i_imm : ex_if.i_rt_data;
  assign w_a_s = $signed(ex_if.i_rs_data);
  assign w_b_s = $signed(w_b);

  always_comb begin
    w_alu = '0;
    case (ex_if.i_alu_op)
      ALU_ADD:  w_alu = ex_if.i_rs_data + w_b;
      ALU_SUB:  w_alu = ex_if.i_rs_data - w_b;
      ALU_AND:  w_alu = ex_if.i_rs_data & w_b;
      ALU_OR:   w_alu = ex_if.i_rs_data | w_b;
      ALU_XOR:  w_alu = ex_if.i_rs_data ^ w_b;
      ALU_NOR:  w_alu = ~(ex_if.i_rs_data | w_b);
      ALU_SLT:  w_alu = NB_BITS'(w_a_s < w_b_s);
      ALU_SLTU: w_alu = NB_BITS'(ex_if.i_rs_data < w_b);
      ALU_SLL:  w_alu = w_b << ex_if.i_shamt;
      ALU_SRL:  w_alu = w_b >> ex_if.i_shamt;
      ALU_SRA:  w_alu = w_b_s >>> ex_if.i_shamt;
      ALU_LUI:  w_alu = w_b << 16;
      default:  w_alu = '0;
    endcase
  end

  always_comb begin
    w_addr = w_alu;
    if (ex_if.i_hilo_sel == HILO_SEL_HI)      w_addr = w_hi;
    else if (ex_if.i_hilo_sel == HILO_SEL_LO) w_addr = w_lo;
  end

`ifdef EX_OVERFLOW_TRAP_EN
  logic r_ovf;
  always_comb begin
    w_kill = 1'b0;
    if (ex_if.i_hilo_sel == HILO_SEL_NONE) begin
      if (ex_if.i_alu_op == ALU_ADD)
        w_kill = (w_a_s[NB_BITS-1] == w_b_s[NB_BITS-1]) && (w_alu[NB_BITS-1] != w_a_s[NB_BITS-1]);
      else if (ex_if.i_alu_op == ALU_SUB)
        w_kill = (w_a_s[NB_BITS-1] != w_b_s[NB_BITS-1]) && (w_alu[NB_BITS-1] != w_a_s[NB_BITS-1]);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst || w_stall) r_ovf <= 1'b0;
    else                  r_ovf <= w_kill;
  end
  assign ex_if.o_ovf = r_ovf;
`else
  assign w_kill = 1'b0;
`endif

  // A dependent instruction waits while the unit is busy; the held slot latches a bubble
  assign w_stall = w_busy & (ex_if.i_md_start | (ex_if.i_hilo_sel != HILO_SEL_NONE));

  mul_div_unit #(.NB_BITS(NB_BITS), .NB_MD_CNT(NB_MD_CNT)) u_mul_div_unit (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (ex_if.i_md_start & ~w_stall),
    .i_op    (ex_if.i_md_op),
    .i_a     (ex_if.i_rs_data),
    .i_b     (ex_if.i_rt_data),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_busy  (w_busy)
  );

  // EX/MEM latch
  always_ff @(posedge i_clk) begin
    if (i_rst || w_stall) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_write_ctl <= '0;
      r_read_ctl  <= '0;
      r_reg_dst   <= '0;
      r_wb_ctl    <= '0;
    end else begin
      r_addr      <= w_addr;
      r_data      <= ex_if.i_rt_data;
      r_write_ctl <= w_kill ? '0 : ex_if.i_write_ctl;
      r_read_ctl  <= ex_if.i_read_ctl;
      r_reg_dst   <= ex_if.i_reg_dst;
      r_wb_ctl    <= w_kill ? '0 : ex_if.i_wb_ctl;
    end
  end

  assign ex_if.o_addr      = r_addr;
  assign ex_if.o_data      = r_data;
  assign ex_if.o_write_ctl = r_write_ctl;
  assign ex_if.o_read_ctl  = r_read_ctl;
  assign ex_if.o_reg_dst   = r_reg_dst;
  assign ex_if.o_wb_ctl    = r_wb_ctl;
  assign ex_if.o_stall     = w_stall;
  assign ex_if.o_md_busy   = w_busy;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Self-checking bench for ex_muldiv_stage: ALU vector table, mul/div sequences with stall
// bubbles, reset abort, and the EX_OVERFLOW_TRAP_EN overflow squash when that macro is defined.
module tb_ex_muldiv_stage;
  import ex_muldiv_stage_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wctl;
    logic [3:0]  rctl;
    logic [4:0]  rd;
    logic [1:0]  wb;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        src;
    logic [31:0] exp_addr;
  } alu_vec_t;

  exp_t     sb[$];
  alu_vec_t vecs[15];

  ex_muldiv_stage_if #(.NB_BITS(32), .NB_ALU_OP(4)) bus ();

  ex_muldiv_stage #(.NB_BITS(32), .NB_ALU_OP(4), .NB_MD_CNT(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .ex_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [4:0] shamt, input logic src,
                       input logic start, input logic [1:0] mdop, input logic [1:0] hsel,
                       input logic [3:0] wctl, input logic [3:0] rctl, input logic [4:0] rd,
                       input logic [1:0] wb);
    bus.i_alu_op    = op;
    bus.i_rs_data   = rs;
    bus.i_rt_data   = rt;
    bus.i_imm       = imm;
    bus.i_shamt     = shamt;
    bus.i_alu_src   = src;
    bus.i_md_start  = start;
    bus.i_md_op     = mdop;
    bus.i_hilo_sel  = hsel;
    bus.i_write_ctl = wctl;
    bus.i_read_ctl  = rctl;
    bus.i_reg_dst   = rd;
    bus.i_wb_ctl    = wb;
  endtask

  task automatic nop();
    drive(ALU_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, HILO_SEL_NONE, 4'h0, 4'h0, 5'd0, 2'd0);
  endtask

  // Expected latch contents for an unstalled instruction built from the stimulus just driven
  function automatic exp_t mk(input logic [31:0] addr);
    exp_t e;
    e.addr = addr;
    e.data = bus.i_rt_data;
    e.wctl = bus.i_write_ctl;
    e.rctl = bus.i_read_ctl;
    e.rd   = bus.i_reg_dst;
    e.wb   = bus.i_wb_ctl;
    return e;
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e.addr = '0; e.data = '0; e.wctl = '0; e.rctl = '0; e.rd = '0; e.wb = '0;
    return e;
  endfunction

  task automatic tick(input exp_t e, input logic exp_stall, input string tag);
    exp_t g;
    #1;
    chk({tag, " stall"}, 32'(bus.o_stall), 32'(exp_stall));
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({tag, " addr"}, bus.o_addr, g.addr);
    chk({tag, " data"}, bus.o_data, g.data);
    chk({tag, " ctl"}, 32'({bus.o_wb_ctl, bus.o_write_ctl, bus.o_read_ctl, bus.o_reg_dst}),
        32'({g.wb, g.wctl, g.rctl, g.rd}));
  endtask

  task automatic md_run(input logic [1:0] mdop, input logic [31:0] a, input logic [31:0] b,
                        input int stall_n, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input string tag);
    drive(ALU_OR, a, b, 32'h0, 5'd0, 1'b0, 1'b1, mdop, HILO_SEL_NONE, 4'h0, 4'h0, 5'd0, 2'd0);
    tick(mk(a | b), 1'b0, {tag, " start"});
    drive(ALU_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, HILO_SEL_LO, 4'h0, 4'hF, 5'd9, 2'b01);
    for (int i = 0; i < stall_n; i++) begin
      chk({tag, " busy"}, 32'(bus.o_md_busy), 32'd1);
      tick(bubble(), 1'b1, {tag, " bubble"});
    end
    tick(mk(exp_lo), 1'b0, {tag, " mflo"});
    drive(ALU_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, HILO_SEL_HI, 4'h0, 4'h3, 5'd10, 2'b01);
    tick(mk(exp_hi), 1'b0, {tag, " mfhi"});
    nop();
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    vecs[0]  = '{ALU_ADD,  32'h00000005, 32'h00000000, 32'hFFFFFFFD, 5'd0, 1'b1, 32'h00000002};
    vecs[1]  = '{ALU_SUB,  32'h00000003, 32'h00000005, 32'h0,        5'd0, 1'b0, 32'hFFFFFFFE};
    vecs[2]  = '{ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        5'd0, 1'b0, 32'h00F000F0};
    vecs[3]  = '{ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        5'd0, 1'b0, 32'hFFF0FFF0};
    vecs[4]  = '{ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        5'd0, 1'b0, 32'hFF00FF00};
    vecs[5]  = '{ALU_NOR,  32'h00000000, 32'h00000000, 32'h0,        5'd0, 1'b0, 32'hFFFFFFFF};
    vecs[6]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h0,        5'd0, 1'b0, 32'h00000001};
    vecs[7]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h0,        5'd0, 1'b0, 32'h00000000};
    vecs[8]  = '{ALU_SLL,  32'h0,        32'h00000001, 32'h0,        5'd4, 1'b0, 32'h00000010};
    vecs[9]  = '{ALU_SRL,  32'h0,        32'h80000000, 32'h0,        5'd4, 1'b0, 32'h08000000};
    vecs[10] = '{ALU_SRA,  32'h0,        32'h80000000, 32'h0,        5'd4, 1'b0, 32'hF8000000};
    vecs[11] = '{ALU_LUI,  32'h0,        32'h0,        32'h00001234, 5'd0, 1'b1, 32'h12340000};
    vecs[12] = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h0,        5'd0, 1'b0, 32'h00000000};
    vecs[13] = '{ALU_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h0,        5'd0, 1'b0, 32'h00000001};
    vecs[14] = '{ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h0,        5'd0, 1'b0, 32'h00000001};

    // Reset held two cycles with random inputs
    rst = 1'b1;
    drive(4'($urandom_range(0, 11)), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
          1'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 5'($urandom),
          2'($urandom));
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst addr", bus.o_addr, 32'h0);
    chk("rst data", bus.o_data, 32'h0);
    chk("rst ctl", 32'({bus.o_wb_ctl, bus.o_write_ctl, bus.o_read_ctl, bus.o_reg_dst}), 32'h0);
    chk("rst stall", 32'(bus.o_stall), 32'h0);
    chk("rst busy", 32'(bus.o_md_busy), 32'h0);
    nop();
    rst = 1'b0;

    drive(ALU_ADD, 32'h5, 32'h0, 32'hFFFFFFFD, 5'd0, 1'b1, 1'b0, 2'd0, HILO_SEL_NONE, 4'h5, 4'hA, 5'd7, 2'b10);
    tick(mk(32'h00000002), 1'b0, "add imm");

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].shamt, vecs[i].src, 1'b0, 2'd0,
            HILO_SEL_NONE, 4'(i), ~4'(i), 5'(i + 1), 2'(i));
      tick(mk(vecs[i].exp_addr), 1'b0, $sformatf("alu[%0d]", i));
    end

    md_run(MD_OP_MULT,  32'hFFFFFFFE, 32'h00000003, 33, 32'hFFFFFFFA, 32'hFFFFFFFF, "mult");
    md_run(MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 32'hFFFFFFFE, "multu");
    md_run(MD_OP_DIV,   32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, "div");
    md_run(MD_OP_DIVU,  32'h00000009, 32'h00000000, 1,  32'hFFFFFFFF, 32'h00000009, "divu0");
    md_run(MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h00000000, "divmin");

    // Reset asserted in cycle 10 of a DIV aborts it and clears HI/LO
    drive(ALU_OR, 32'd100, 32'd7, 32'h0, 5'd0, 1'b0, 1'b1, MD_OP_DIV, HILO_SEL_NONE, 4'h0, 4'h0, 5'd0, 2'd0);
    tick(mk(32'd103), 1'b0, "abort start");
    nop();
    for (int i = 1; i < 10; i++) tick(bubble(), 1'b0, "abort run");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy", 32'(bus.o_md_busy), 32'h0);
    rst = 1'b0;
    drive(ALU_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, HILO_SEL_HI, 4'h0, 4'h1, 5'd2, 2'b01);
    tick(mk(32'h0), 1'b0, "abort mfhi");
    drive(ALU_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, HILO_SEL_LO, 4'h0, 4'h1, 5'd2, 2'b01);
    tick(mk(32'h0), 1'b0, "abort mflo");

`ifdef EX_OVERFLOW_TRAP_EN
    begin
      exp_t e;
      drive(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, HILO_SEL_NONE,
            4'hF, 4'h6, 5'd3, 2'b11);
      e = mk(32'h80000000);
      e.wctl = 4'h0;
      e.wb   = 2'b00;
      tick(e, 1'b0, "ovf add");
      chk("ovf pulse", 32'(bus.o_ovf), 32'h1);
      nop();
      tick(bubble(), 1'b0, "ovf after");
      chk("ovf clear", 32'(bus.o_ovf), 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
